// File: rtl/iecdrv_rom_share.sv
// Shared drive ROM front end: CPU phase strobes, IEC input sync,
// ROM size detection and round-robin ROM reads for up to four drives.
module iecdrv_rom_share #(
  parameter int NDR       = 2,
  parameter bit PARPORT   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  input  logic           pause,
  input  logic           iec_atn_i,
  input  logic           iec_data_i,
  input  logic           iec_clk_i,
  input  logic           iec_fclk_i,
  output logic           iec_atn,
  output logic           iec_data,
  output logic           iec_clk,
  output logic           iec_fclk,
  input  logic           rom_wr,
  input  logic [14:0]    rom_addr,
  input  logic [7:0]     rom_data,
  input  logic           rom_std,
  input  logic [NDR*15-1:0] drv_addr,
  output logic [NDR*8-1:0]  drv_data,
  output logic           ph2_r,
  output logic           ph2_f,
  output logic [1:0]     rom_sz,
  output logic           empty8k
);

  localparam int N = (NDR < 1) ? 1 : ((NDR > 4) ? 4 : NDR);

  logic [3:0]  s1, s2;
  logic [3:0]  div;
  logic        ena, ena1;
  logic        stdrom;
  logic        rom_32k_i, rom_16k_i;
  logic        nonblank;
  logic [2:0]  state;
  logic [1:0]  wslot;
  logic [14:0] a;
  logic [14:0] mem_a;
  logic [7:0]  rom_q, rom_d;
  logic [7:0]  dd [4];
  logic [7:0]  rom [0:16383];
  logic        unused_ok;

  assign stdrom    = PARPORT ? rom_std : 1'b1;
  assign nonblank  = (rom_data != 8'h00) && (rom_data != 8'hFF);
  assign wslot     = state[1:0] - 2'd3;
  assign unused_ok = mem_a[14];

  assign {iec_atn, iec_data, iec_clk, iec_fclk} = s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= {iec_atn_i, iec_data_i, iec_clk_i, iec_fclk_i};
      s2 <= s1;
    end
  end

  // pause is sampled into ena only between strobe boundaries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div   <= '0;
      ena   <= 1'b0;
      ena1  <= 1'b0;
      ph2_r <= 1'b0;
      ph2_f <= 1'b0;
    end else begin
      ph2_r <= 1'b0;
      ph2_f <= 1'b0;
      ena1  <= ~pause;
      if (div[2:0] != 3'd0) ena <= ena1;
      if (ce) begin
        div <= div + 4'd1;
        if (div[2:0] == 3'd0 && ena) begin
          ph2_r <= ~div[3];
          ph2_f <= div[3];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_32k_i <= 1'b1;
      rom_16k_i <= 1'b1;
      empty8k   <= 1'b1;
      rom_sz    <= 2'b11;
    end else begin
      if (rom_wr && rom_addr == 15'd0) empty8k <= 1'b1;
      if (rom_wr && nonblank) begin
        {rom_32k_i, rom_16k_i} <= rom_addr[14:13];
        if (rom_addr[14:8] != 7'd0 && rom_addr[14:13] == 2'd0)
          empty8k <= 1'b0;
      end
      rom_sz <= {rom_32k_i, rom_32k_i | rom_16k_i};
    end
  end

  // read-before-write: a colliding slot read sees the old byte
  always_ff @(posedge clk) begin
    if (!PARPORT && rom_wr) rom[rom_addr[13:0]] <= rom_data;
    rom_q <= rom[mem_a[13:0]];
  end

  always_comb begin
    a = '0;
    for (int i = 0; i < N; i++)
      if (state[1:0] == i[1:0]) a = drv_addr[i*15 +: 15];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= 3'd7;
      mem_a <= '0;
      rom_d <= '0;
      for (int i = 0; i < 4; i++) dd[i] <= '0;
    end else begin
      if (ph2_f) state <= 3'd0;
      else if (state != 3'd7) state <= state + 3'd1;
      if (!state[2])
        mem_a <= {a[14] & rom_sz[1],
                  a[13] & (rom_sz[0] | stdrom),
                  a[12:0]};
      rom_d <= rom_q;
      if (state >= 3'd3 && state <= 3'd6)
        for (int i = 0; i < N; i++)
          if (wslot == i[1:0]) dd[i] <= rom_d;
    end
  end

  generate
    for (genvar g = 0; g < NDR; g++) begin : g_out
      if (g < N) begin : g_live
        assign drv_data[g*8 +: 8] = dd[g];
      end else begin : g_dead
        assign drv_data[g*8 +: 8] = 8'h00;
      end
    end
  endgenerate

endmodule

// File: tb/tb_iecdrv_rom_share.sv
// Bench for iecdrv_rom_share: strobes, pause, sync,
// size detection and scoreboarded slot reads.
module tb_iecdrv_rom_share;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce, pause;
  logic        iec_atn_i, iec_data_i, iec_clk_i, iec_fclk_i;
  logic        iec_atn, iec_data, iec_clk, iec_fclk;
  logic        rom_wr, rom_std;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [59:0] drv_addr;
  logic [31:0] drv_data;
  logic        ph2_r, ph2_f;
  logic [1:0]  rom_sz;
  logic        empty8k;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mem [16384];
  logic [7:0] exp_q [$];

  iecdrv_rom_share #(.NDR(4), .PARPORT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .pause(pause),
    .iec_atn_i(iec_atn_i), .iec_data_i(iec_data_i),
    .iec_clk_i(iec_clk_i), .iec_fclk_i(iec_fclk_i),
    .iec_atn(iec_atn), .iec_data(iec_data),
    .iec_clk(iec_clk), .iec_fclk(iec_fclk),
    .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_std(rom_std), .drv_addr(drv_addr), .drv_data(drv_data),
    .ph2_r(ph2_r), .ph2_f(ph2_f), .rom_sz(rom_sz),
    .empty8k(empty8k)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(bit f, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(f ? ph2_f : ph2_r) && n < 64);
    if (n >= 64) chk("strobe_timeout", 32'(n), 32'd0);
  endtask

  task automatic count_strobes(int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(ph2_r) + int'(ph2_f);
    end
  endtask

  task automatic rom_write(logic [14:0] ad, logic [7:0] d);
    rom_addr = ad;
    rom_data = d;
    rom_wr   = 1'b1;
    @(negedge clk);
    rom_wr = 1'b0;
    mem[ad[13:0]] = d;
    @(negedge clk);
  endtask

  task automatic size_chk(string tag, logic [1:0] sz, logic e);
    chk({tag, "_sz"}, 32'(rom_sz), 32'(sz));
    chk({tag, "_e8"}, 32'(empty8k), 32'(e));
  endtask

  logic [14:0] aa [4];
  logic [14:0] bb [4];
  logic [3:0]  cur, nxt;
  int n, c;

  initial begin
    reset_n = 1'b1; ce = 1'b1; pause = 1'b0; rom_std = 1'b0;
    {iec_atn_i, iec_data_i, iec_clk_i, iec_fclk_i} = 4'hF;
    rom_wr = 1'b0; rom_addr = '0; rom_data = '0; drv_addr = '0;

    tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ph2", {30'd0, ph2_r, ph2_f}, 32'd0);
    chk("rst_sz", 32'(rom_sz), 32'd3);
    chk("rst_e8", 32'(empty8k), 32'd1);
    chk("rst_drv", drv_data, 32'd0);
    chk("rst_iec", {28'd0, iec_atn, iec_data, iec_clk, iec_fclk},
        32'hF);
    tick(2);
    chk("rst_hold", {30'd0, ph2_r, ph2_f}, 32'd0);
    reset_n = 1'b1;

    wait_strobe(1'b1, n);
    chk("first_f", 32'(n), 32'd9);
    wait_strobe(1'b0, n);
    chk("f_to_r", 32'(n), 32'd8);
    @(negedge clk);
    chk("r_width", 32'(ph2_r), 32'd0);
    wait_strobe(1'b1, n);
    chk("r_to_f", 32'(n), 32'd7);

    pause = 1'b1;
    tick(16);
    count_strobes(32, c);
    chk("paused", 32'(c), 32'd0);
    pause = 1'b0;
    tick(16);
    count_strobes(32, c);
    chk("resumed", 32'(c), 32'd4);

    cur = 4'hF;
    for (int i = 0; i < 6; i++) begin
      nxt = 4'($urandom);
      nxt[2] = ~cur[2];
      {iec_atn_i, iec_data_i, iec_clk_i, iec_fclk_i} = nxt;
      @(negedge clk);
      chk("sync1", {28'd0, iec_atn, iec_data, iec_clk, iec_fclk},
          32'(cur));
      @(negedge clk);
      chk("sync2", {28'd0, iec_atn, iec_data, iec_clk, iec_fclk},
          32'(nxt));
      cur = nxt;
    end

    rom_write(15'h0123, 8'hAA);
    size_chk("w0123", 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) rom_write(15'h1000 + 15'(i), 8'hAA);
    rom_write(15'h2001, 8'h55);
    size_chk("w2001", 2'b01, 1'b0);
    rom_write(15'h4000, 8'hFF);
    size_chk("wff", 2'b01, 1'b0);
    rom_write(15'h0000, 8'h00);
    size_chk("w0", 2'b01, 1'b1);
    rom_write(15'h0105, 8'h12);
    size_chk("w0105", 2'b00, 1'b0);

    aa = '{15'h0000, 15'h5000, 15'h2001, 15'h0105};
    bb = '{15'h0105, 15'h6001, 15'h1003, 15'h4123};
    drv_addr = {aa[3], aa[2], aa[1], aa[0]};
    wait_strobe(1'b1, n);
    tick(10);
    drv_addr = {bb[3], bb[2], bb[1], bb[0]};
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(mem[aa[s][13:0]]);
      exp_q.push_back(mem[bb[s][13:0]]);
    end
    wait_strobe(1'b1, n);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
        if (k == 4 + s || k == 5 + s) begin
          if (exp_q.size() == 0) chk("q_empty", 32'd1, 32'd0);
          else chk($sformatf("slot%0d_k%0d", s, k),
                   32'(drv_data[s*8 +: 8]), 32'(exp_q.pop_front()));
        end
      end
    end
    chk("q_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
